// File: rtl/mem_arbiter.sv
// mem_arbiter: serialises CPU and DMA accesses onto one single-port memory.
// The CPU wins by default. DMA is guaranteed a grant once MAX_BURST
// consecutive CPU grants have gone out while it was waiting. Only one
// transaction is ever in flight, and every output comes from a register.
module mem_arbiter #(
  parameter int AW        = 16,
  parameter int DW        = 16,
  parameter int RD_LAT    = 1,
  parameter int MAX_BURST = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic          cpu_gnt,
  output logic          cpu_done,
  output logic [DW-1:0] cpu_rdata,
  input  logic          dma_req,
  input  logic          dma_we,
  input  logic [AW-1:0] dma_addr,
  input  logic [DW-1:0] dma_wdata,
  output logic          dma_gnt,
  output logic          dma_done,
  output logic [DW-1:0] dma_rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy
);

  localparam int             CW        = $clog2(RD_LAT + 1);
  localparam logic [3:0]     BURST_LIM = 4'(MAX_BURST);
  localparam logic [CW-1:0]  LAT_LOAD  = CW'(RD_LAT);
  localparam logic [CW-1:0]  CNT_ONE   = CW'(1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_e;
  typedef enum logic       {OWN_CPU, OWN_DMA}  owner_e;

  state_e          state_q, state_d;
  owner_e          owner_q, owner_d;
  logic            we_q, we_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [DW-1:0]   wdata_q, wdata_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [3:0]      streak_q, streak_d;
  logic            dma_wins;

  logic            cpu_gnt_q, cpu_gnt_d, cpu_done_q, cpu_done_d;
  logic            dma_gnt_q, dma_gnt_d, dma_done_q, dma_done_d;
  logic [DW-1:0]   cpu_rdata_q, cpu_rdata_d, dma_rdata_q, dma_rdata_d;
  logic            mem_en_q, mem_en_d, mem_we_q, mem_we_d;
  logic [AW-1:0]   mem_addr_q, mem_addr_d;
  logic [DW-1:0]   mem_wdata_q, mem_wdata_d;
  logic            busy_q, busy_d;

  // Next-state logic: arbitration in IDLE, memory strobe for ISSUE, latency countdown in WAIT.
  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path through the case infers a latch.
    state_d     = state_q;
    owner_d     = owner_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    cnt_d       = cnt_q;
    streak_d    = streak_q;
    cpu_rdata_d = cpu_rdata_q;
    dma_rdata_d = dma_rdata_q;
    cpu_gnt_d   = 1'b0;
    cpu_done_d  = 1'b0;
    dma_gnt_d   = 1'b0;
    dma_done_d  = 1'b0;
    mem_en_d    = 1'b0;
    mem_we_d    = 1'b0;
    mem_addr_d  = '0;
    mem_wdata_d = '0;
    dma_wins    = 1'b0;

    case (state_q)
      IDLE: begin
        if (cpu_req || dma_req) begin
          // DMA takes the slot when it is alone, or when the CPU has used up its burst.
          dma_wins = dma_req && (!cpu_req || streak_q == BURST_LIM);
          if (dma_wins) begin
            owner_d   = OWN_DMA;
            we_d      = dma_we;
            addr_d    = dma_addr;
            wdata_d   = dma_wdata;
            streak_d  = '0;
            dma_gnt_d = 1'b1;
          end else begin
            owner_d   = OWN_CPU;
            we_d      = cpu_we;
            addr_d    = cpu_addr;
            wdata_d   = cpu_wdata;
            streak_d  = dma_req ? streak_q + 4'd1 : 4'd0;
            cpu_gnt_d = 1'b1;
          end
          // Strobe values are set one edge early so they appear registered in the ISSUE cycle.
          mem_en_d    = 1'b1;
          mem_we_d    = we_d;
          mem_addr_d  = addr_d;
          mem_wdata_d = wdata_d;
          state_d     = ISSUE;
        end
      end

      ISSUE: begin
        if (we_q) begin
          state_d    = IDLE;
          cpu_done_d = (owner_q == OWN_CPU);
          dma_done_d = (owner_q == OWN_DMA);
        end else begin
          state_d = WAIT;
          cnt_d   = LAT_LOAD;
        end
      end

      WAIT: begin
        if (cnt_q == CNT_ONE) begin
          // mem_rdata is valid in this cycle; only the owner's read register is updated.
          state_d = IDLE;
          if (owner_q == OWN_CPU) begin
            cpu_rdata_d = mem_rdata;
            cpu_done_d  = 1'b1;
          end else begin
            dma_rdata_d = mem_rdata;
            dma_done_d  = 1'b1;
          end
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end

      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  // State, command latch and registered outputs; reset aborts any transaction in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      owner_q     <= OWN_CPU;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      cnt_q       <= '0;
      streak_q    <= '0;
      cpu_gnt_q   <= 1'b0;
      cpu_done_q  <= 1'b0;
      cpu_rdata_q <= '0;
      dma_gnt_q   <= 1'b0;
      dma_done_q  <= 1'b0;
      dma_rdata_q <= '0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      busy_q      <= 1'b0;
    end else begin
      // NOTE: non-blocking so every register takes its value from the pre-edge state.
      state_q     <= state_d;
      owner_q     <= owner_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      cnt_q       <= cnt_d;
      streak_q    <= streak_d;
      cpu_gnt_q   <= cpu_gnt_d;
      cpu_done_q  <= cpu_done_d;
      cpu_rdata_q <= cpu_rdata_d;
      dma_gnt_q   <= dma_gnt_d;
      dma_done_q  <= dma_done_d;
      dma_rdata_q <= dma_rdata_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      busy_q      <= busy_d;
    end
  end

  assign cpu_gnt   = cpu_gnt_q;
  assign cpu_done  = cpu_done_q;
  assign cpu_rdata = cpu_rdata_q;
  assign dma_gnt   = dma_gnt_q;
  assign dma_done  = dma_done_q;
  assign dma_rdata = dma_rdata_q;
  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign busy      = busy_q;

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port arbiter sharing the single-port 16-bit system memory between the CPU controller (instruction fetch and LD/ST) and a DMA requester. It serialises requests, one outstanding transaction at a time. It enforces CPU-priority arbitration with a bounded-starvation guarantee for DMA. It sits between the controller/datapath memory signals and the memory array, whose read latency is fixed and parameterised.

## Interface
- AW, 16: address width.
- DW, 16: data width.
- RD_LAT, 1: cycles from the mem_en cycle until mem_rdata is valid (legal 1..4).
- MAX_BURST, 4: maximum consecutive CPU grants while DMA is waiting (legal 1..15).

- clk  in  1  system clock, rising edge.
- rst  in  1  reset; asynchronous, active-high.
- cpu_req  in  1  CPU request; held with the command until cpu_gnt.
- cpu_we  in  1  1 = write, 0 = read.
- cpu_addr  in  AW  address.
- cpu_wdata  in  DW  write data.
- cpu_gnt  out  1  one-cycle pulse: command issued to memory.
- cpu_done  out  1  one-cycle pulse: transaction complete.
- cpu_rdata  out  DW  read data, valid from cpu_done and held until the next CPU read completes.
- dma_req, dma_we, dma_addr, dma_wdata, dma_gnt, dma_done, dma_rdata: same widths and meaning as the cpu_* ports, for DMA.
- mem_en  out  1  memory access strobe.
- mem_we  out  1  memory write enable, qualified by mem_en.
- mem_addr  out  AW  memory address.
- mem_wdata  out  DW  memory write data.
- mem_rdata  in  DW  memory read data, valid RD_LAT cycles after the mem_en cycle.
- busy  out  1  high whenever state is not IDLE.

## Operation
- FSM states: IDLE, ISSUE, WAIT.
- IDLE
  - Samples cpu_req and dma_req at each edge.
  - If either is asserted: picks the winner, latches owner, we, addr and wdata, and goes to ISSUE.
- ISSUE (exactly one cycle)
  - mem_en=1; mem_we, mem_addr and mem_wdata come from the latched command.
  - The owner's gnt=1.
  - Write: next state IDLE, owner's done=1 in that next cycle.
  - Read: next state WAIT, counter loaded with RD_LAT.
- WAIT
  - Counter decrements each cycle.
  - On the edge ending the cycle in which mem_rdata is valid: capture into the owner's rdata, pulse the owner's done, return to IDLE.
- Arbitration
  - CPU wins by default.
  - streak counter (4 bits):
    - Increments on each CPU grant issued while dma_req was high.
    - Clears on a CPU grant with dma_req low, and on any DMA grant.
  - If both ports request and streak == MAX_BURST, DMA wins.
  - DMA alone is always granted.
- The non-owner's rdata is never modified.
- A write never modifies rdata.
- Requesters must not drop req or change the command before gnt. The arbiter only samples in IDLE, so a req dropped early is either ignored or served; no recovery is defined.
- All outputs are registered.
  - mem_* are 0 outside ISSUE.
  - gnt and done are never high in two consecutive cycles for the same transaction.

## Timing
- Let C be the cycle in which mem_en is high.
- Request to issue: req high before edge E0 in IDLE gives mem_en and gnt in the cycle after E0.
- Write: done in cycle C+1. The next sample is at the end of C+1, so the next issue is no earlier than C+2 (2-cycle throughput).
- Read: mem_rdata valid in C+RD_LAT. done and rdata appear in C+RD_LAT+1, with state IDLE in the same cycle. The next issue is no earlier than C+RD_LAT+2.
- busy is high from C through the last WAIT cycle. busy is low in the done cycle.
- Reset (asynchronous, any state, including mid-WAIT):
  - State goes to IDLE and streak clears.
  - All outputs go to 0, including both rdata registers.
  - The in-flight transaction is aborted with no done.
- After rst deasserts, the first edge samples requests normally.

## Test plan
- CPU write addr 0x0010, data 0xBEEF: one cycle with mem_en=1, mem_we=1, mem_addr=0x0010, mem_wdata=0xBEEF and cpu_gnt=1; cpu_done=1 the next cycle; dma_* outputs stay 0.
- CPU read addr 0x0020 with RD_LAT=2, memory model returning 0x1234: mem_we=0 in cycle C; cpu_done=1 and cpu_rdata=0x1234 in C+3; busy high for C..C+2.
- Both ports requesting continuously (writes), MAX_BURST=4: grant order C,C,C,C,D,C,C,C,C,D; grants spaced exactly 2 cycles apart.
- DMA-only reads, RD_LAT=1, addresses 0x0100 then 0x0101: issues spaced 3 cycles apart; dma_rdata updates per read; cpu_rdata remains 0.
- rst pulsed during WAIT of a CPU read: all outputs 0 immediately; no cpu_done; after release, a new DMA write completes with standard timing.
- CPU and DMA reads requested in the same cycle, with streak 0: CPU is served first, then DMA. cpu_rdata is unchanged by the DMA read, and dma_rdata is unchanged by the CPU read.
